adder_pipe_mc: RTL and testbench
================================

Name: adder_pipe_mc

Overview:
- Parametrised, multi-channel, pipelined add/subtract datapath; next-generation DUT for the adder verification environment.
- Processes CHANNELS independent WIDTH-bit lanes per beat, with signed overflow detection and optional saturation.
- valid/ready handshake on input and output, full backpressure support.
- Sits between the bench driver interface and the monitor/scoreboard; one beat per cycle at full throughput.

Parameters:
- WIDTH, 8, bits per lane operand and result (>=2)
- CHANNELS, 4, number of independent lanes per beat (>=1)
- STAGES, 2, pipeline depth = latency in cycles (>=1)
- SATURATE, 0, 1 = clamp signed overflow to max/min, 0 = wrap

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept beat this cycle
- op  in  1  0 = a+b, 1 = a-b (all lanes)
- a  in  CHANNELS*WIDTH  lane i operand at [i*WIDTH +: WIDTH]
- b  in  CHANNELS*WIDTH  lane i operand
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- sum  out  CHANNELS*WIDTH  lane results
- carry  out  CHANNELS  per-lane carry-out; for sub, 1 = no borrow
- ovf  out  CHANNELS  per-lane signed overflow

Behaviour:
- Reset: one clock; reset asynchronous, active-high; stage valid bits, out_valid, sum, carry and ovf clear to 0 immediately on rst assertion; in_ready forced 0 while rst high, 1 on first cycle after release (pipeline empty).
- Input handshake on in_valid && in_ready at rising edge; output handshake on out_valid && out_ready.
- Arithmetic in stage 1: add = a+b; sub = a+~b+1 at WIDTH+1 bits; carry = bit WIDTH. ovf = operand sign bits (b inverted for sub) equal and result sign differs.
- SATURATE=1 and ovf: sum = 0x7F..F if a is positive, 0x80..0 if a is negative; carry unchanged. SATURATE=0: wrapped result.
- Stages 2..STAGES register result unchanged; final stage drives outputs directly from registers (no combinational path a/b -> sum).
- Pipeline control: stage k loads when empty or stage k+1 advances; final stage advances when out_ready or !out_valid. in_ready = !stage1_valid || stage1 advancing (combinational from out_ready allowed).
- Latency: beat accepted at edge N appears with out_valid=1 after edge N+STAGES if no stall.
- Throughput: one beat/cycle with out_ready held 1.
- Stall: out_valid=1 && out_ready=0 holds sum/carry/ovf stable; no bubble is generated inside; capacity = STAGES beats, then in_ready=0.
- Order preserved; no beat dropped or duplicated.
- Simultaneous output handshake and new input on a full pipe: both occur same cycle, no lost cycle.
- Reset mid-operation: all in-flight beats discarded; nothing emitted after release until new input.
- Data on a,b,op ignored when in_valid=0; outputs undefined-free (held) when out_valid=0.

Optional Feature:
- Macro ADDER_PIPE_STATS_EN.
- Defined: adds output ovf_count (16 bits); on each output handshake adds popcount(ovf) of that beat; saturates at 0xFFFF; clears on rst.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- WIDTH=8, CHANNELS=4, STAGES=2: all lanes 0x10+0x20, op=0, out_ready=1 -> out_valid 2 cycles later, sum 0x30 each lane, carry 0, ovf 0.
- Lane0 0x7F+0x01, lane1 0xFF+0x01 -> SATURATE=0: 0x80 ovf1 carry0 / 0x00 ovf0 carry1; SATURATE=1: lane0 0x7F ovf1.
- op=1: 0x05-0x07 -> 0xFE carry0 ovf0; 0x80-0x01 -> 0x7F carry1 ovf1 (SATURATE=1: 0x80).
- out_ready=0, drive 3 consecutive beats -> 2 accepted, in_ready=0 on third; out_ready=1 -> 3 beats out in order, sums exact, outputs stable while stalled.
- 2 beats in flight, assert rst 1 cycle -> out_valid 0 same cycle, in_ready 0 during rst, no stale beat after release.
- ADDER_PIPE_STATS_EN: beat with 3 overflowing lanes then beat with 1 -> ovf_count 3 then 4; rst -> 0.

Source files
------------

// File: rtl/adder_pipe_mc.sv
// Multi-lane pipelined add/subtract datapath with signed overflow detection,
// optional saturation and valid/ready flow control. Define ADDER_PIPE_STATS_EN to add ovf_count.
module adder_pipe_mc #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int STAGES   = 2,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      op,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [CHANNELS*WIDTH-1:0] b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] sum,
  output logic [CHANNELS-1:0]       carry,
  output logic [CHANNELS-1:0]       ovf
`ifdef ADDER_PIPE_STATS_EN
  ,
  output logic [15:0]               ovf_count
`endif
);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [CHANNELS*WIDTH-1:0] s1_sum;
  logic [CHANNELS-1:0]       s1_carry;
  logic [CHANNELS-1:0]       s1_ovf;
  logic [WIDTH-1:0]          a_lane;
  logic [WIDTH-1:0]          b_lane;
  logic [WIDTH:0]            full;

  logic [CHANNELS*WIDTH-1:0] pipe_sum   [STAGES];
  logic [CHANNELS-1:0]       pipe_carry [STAGES];
  logic [CHANNELS-1:0]       pipe_ovf   [STAGES];
  logic [STAGES-1:0]         pipe_vld;
  logic [STAGES-1:0]         load_en;

  // Subtraction reuses the adder as a + ~b + 1, so carry-out means "no borrow".
  always_comb begin
    s1_sum   = '0;
    s1_carry = '0;
    s1_ovf   = '0;
    a_lane   = '0;
    b_lane   = '0;
    full     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      a_lane = a[i*WIDTH +: WIDTH];
      b_lane = op ? ~b[i*WIDTH +: WIDTH] : b[i*WIDTH +: WIDTH];
      full   = {1'b0, a_lane} + {1'b0, b_lane} + {{WIDTH{1'b0}}, op};
      s1_carry[i] = full[WIDTH];
      s1_ovf[i]   = (a_lane[WIDTH-1] == b_lane[WIDTH-1]) &&
                    (full[WIDTH-1] != a_lane[WIDTH-1]);
      if ((SATURATE != 0) && s1_ovf[i])
        s1_sum[i*WIDTH +: WIDTH] = a_lane[WIDTH-1] ? MIN_NEG : MAX_POS;
      else
        s1_sum[i*WIDTH +: WIDTH] = full[WIDTH-1:0];
    end
  end

  // A stage may load when it is empty or its contents move on this cycle;
  // the chain is resolved from the output end so a full pipe keeps streaming.
  always_comb begin
    load_en = '0;
    load_en[STAGES-1] = !pipe_vld[STAGES-1] || out_ready;
    for (int k = STAGES-2; k >= 0; k--)
      load_en[k] = !pipe_vld[k] || load_en[k+1];
  end

  assign in_ready = load_en[0] && !rst;

  // Data registers only change when a valid beat arrives, so idle outputs hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int k = 0; k < STAGES; k++) begin
        pipe_sum[k]   <= '0;
        pipe_carry[k] <= '0;
        pipe_ovf[k]   <= '0;
      end
    end else begin
      if (load_en[0]) begin
        pipe_vld[0] <= in_valid;
        if (in_valid) begin
          pipe_sum[0]   <= s1_sum;
          pipe_carry[0] <= s1_carry;
          pipe_ovf[0]   <= s1_ovf;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load_en[k]) begin
          pipe_vld[k] <= pipe_vld[k-1];
          if (pipe_vld[k-1]) begin
            pipe_sum[k]   <= pipe_sum[k-1];
            pipe_carry[k] <= pipe_carry[k-1];
            pipe_ovf[k]   <= pipe_ovf[k-1];
          end
        end
      end
    end
  end

  assign out_valid = pipe_vld[STAGES-1];
  assign sum       = pipe_sum[STAGES-1];
  assign carry     = pipe_carry[STAGES-1];
  assign ovf       = pipe_ovf[STAGES-1];

`ifdef ADDER_PIPE_STATS_EN
  logic [16:0] ovf_pop;
  logic [16:0] count_next;

  always_comb begin
    ovf_pop = '0;
    for (int i = 0; i < CHANNELS; i++)
      ovf_pop = ovf_pop + {16'd0, ovf[i]};
    count_next = {1'b0, ovf_count} + ovf_pop;
  end

  // Counts overflowing lanes of delivered beats, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_count <= '0;
    else if (out_valid && out_ready)
      ovf_count <= count_next[16] ? 16'hFFFF : count_next[15:0];
  end
`endif

endmodule

// File: tb/tb_adder_pipe_mc.sv
// Directed bench for adder_pipe_mc: one wrapping and one saturating instance share stimulus.
module tb_adder_pipe_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_ready = 1'b0;

  logic        w_in_ready, w_out_valid, s_in_ready, s_out_valid;
  logic [31:0] w_sum, s_sum;
  logic [3:0]  w_carry, w_ovf, s_carry, s_ovf;
`ifdef ADDER_PIPE_STATS_EN
  logic [15:0] w_ovf_count, s_ovf_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  adder_pipe_mc #(.WIDTH(8), .CHANNELS(4), .STAGES(2), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .op(op),
    .a(a), .b(b), .out_valid(w_out_valid), .out_ready(out_ready),
    .sum(w_sum), .carry(w_carry), .ovf(w_ovf)
`ifdef ADDER_PIPE_STATS_EN
    , .ovf_count(w_ovf_count)
`endif
  );

  adder_pipe_mc #(.WIDTH(8), .CHANNELS(4), .STAGES(2), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .op(op),
    .a(a), .b(b), .out_valid(s_out_valid), .out_ready(out_ready),
    .sum(s_sum), .carry(s_carry), .ovf(s_ovf)
`ifdef ADDER_PIPE_STATS_EN
    , .ovf_count(s_ovf_count)
`endif
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if (w_out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", w_out_valid); end
    tests_run++;
    if (w_in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 0", w_in_ready); end
    tests_run++;
    if ({w_sum, w_carry, w_ovf} !== 40'd0) begin tests_failed++; $display("[TB] FAIL reset_outputs: got %h expected 0", {w_sum, w_carry, w_ovf}); end
    rst = 1'b0;
    #1;
    tests_run++;
    if (w_in_ready !== 1'b1 || s_in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL release_in_ready: got %b%b expected 11", w_in_ready, s_in_ready); end
  endtask

  task automatic test_basic_add();
    out_ready = 1'b1;
    in_valid = 1'b1; op = 1'b0; a = 32'h10101010; b = 32'h20202020;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (w_out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_latency_early: got %b expected 0", w_out_valid); end
    tick();
    tests_run++;
    if (w_out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_out_valid: got %b expected 1", w_out_valid); end
    tests_run++;
    if (w_sum !== 32'h30303030) begin tests_failed++; $display("[TB] FAIL basic_sum: got %h expected 30303030", w_sum); end
    tests_run++;
    if (w_carry !== 4'h0 || w_ovf !== 4'h0) begin tests_failed++; $display("[TB] FAIL basic_flags: got c=%b o=%b expected 0000/0000", w_carry, w_ovf); end
    tick();
    tests_run++;
    if (w_out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_drain: got %b expected 0", w_out_valid); end
  endtask

  task automatic test_overflow_add();
    out_ready = 1'b1;
    in_valid = 1'b1; op = 1'b0; a = 32'h0000FF7F; b = 32'h00000101;
    tick();
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (w_sum !== 32'h00000080) begin tests_failed++; $display("[TB] FAIL add_wrap_sum: got %h expected 00000080", w_sum); end
    tests_run++;
    if (w_carry !== 4'b0010 || w_ovf !== 4'b0001) begin tests_failed++; $display("[TB] FAIL add_wrap_flags: got c=%b o=%b expected 0010/0001", w_carry, w_ovf); end
    tests_run++;
    if (s_sum !== 32'h0000007F) begin tests_failed++; $display("[TB] FAIL add_sat_sum: got %h expected 0000007F", s_sum); end
    tests_run++;
    if (s_carry !== 4'b0010 || s_ovf !== 4'b0001) begin tests_failed++; $display("[TB] FAIL add_sat_flags: got c=%b o=%b expected 0010/0001", s_carry, s_ovf); end
    tick();
  endtask

  task automatic test_subtract();
    out_ready = 1'b1;
    in_valid = 1'b1; op = 1'b1; a = 32'h7F008005; b = 32'h80000107;
    tick();
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (w_sum !== 32'hFF007FFE) begin tests_failed++; $display("[TB] FAIL sub_wrap_sum: got %h expected FF007FFE", w_sum); end
    tests_run++;
    if (w_carry !== 4'b0110 || w_ovf !== 4'b1010) begin tests_failed++; $display("[TB] FAIL sub_wrap_flags: got c=%b o=%b expected 0110/1010", w_carry, w_ovf); end
    tests_run++;
    if (s_sum !== 32'h7F0080FE) begin tests_failed++; $display("[TB] FAIL sub_sat_sum: got %h expected 7F0080FE", s_sum); end
    tests_run++;
    if (s_carry !== 4'b0110) begin tests_failed++; $display("[TB] FAIL sub_sat_carry: got %b expected 0110", s_carry); end
    tick();
    op = 1'b0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'h01010101; b = 32'h01010101;
    #1;
    tests_run++;
    if (w_in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_ready_a: got %b expected 1", w_in_ready); end
    tick();
    a = 32'h03030303;
    tests_run++;
    if (w_in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_ready_b: got %b expected 1", w_in_ready); end
    tick();
    a = 32'h05050505;
    tests_run++;
    if (w_in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_full: got %b expected 0", w_in_ready); end
    tests_run++;
    if (w_out_valid !== 1'b1 || w_sum !== 32'h02020202) begin tests_failed++; $display("[TB] FAIL bp_head: got v=%b %h expected 1 02020202", w_out_valid, w_sum); end
    tick();
    tick();
    tests_run++;
    if (w_out_valid !== 1'b1 || w_sum !== 32'h02020202 || w_in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_stable: got v=%b %h r=%b expected 1 02020202 0", w_out_valid, w_sum, w_in_ready); end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (w_in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_release_ready: got %b expected 1", w_in_ready); end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (w_out_valid !== 1'b1 || w_sum !== 32'h04040404) begin tests_failed++; $display("[TB] FAIL bp_second: got v=%b %h expected 1 04040404", w_out_valid, w_sum); end
    tick();
    tests_run++;
    if (w_out_valid !== 1'b1 || w_sum !== 32'h06060606) begin tests_failed++; $display("[TB] FAIL bp_third: got v=%b %h expected 1 06060606", w_out_valid, w_sum); end
    tick();
    tests_run++;
    if (w_out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_drained: got %b expected 0", w_out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_vec [4];
    logic [31:0] exp_vec [4];
    a_vec   = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    exp_vec = '{32'h12121212, 32'h23232323, 32'h34343434, 32'h45454545};
    out_ready = 1'b1;
    b = 32'h01010101;
    for (int t = 0; t < 6; t++) begin
      if (t < 4) begin
        in_valid = 1'b1; a = a_vec[t];
        #1;
        tests_run++;
        if (w_in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected 1", t, w_in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (t >= 1 && t <= 4) begin
        tests_run++;
        if (w_out_valid !== 1'b1 || w_sum !== exp_vec[t-1]) begin tests_failed++; $display("[TB] FAIL b2b_out[%0d]: got v=%b %h expected 1 %h", t-1, w_out_valid, w_sum, exp_vec[t-1]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'h0A0A0A0A; b = 32'h01010101;
    tick();
    a = 32'h0B0B0B0B;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests_run++;
    if (w_out_valid !== 1'b0 || s_out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_out_valid: got %b%b expected 00", w_out_valid, s_out_valid); end
    tests_run++;
    if (w_in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_in_ready: got %b expected 0", w_in_ready); end
    tests_run++;
    if (w_sum !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_sum: got %h expected 0", w_sum); end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      tests_run++;
      if (w_out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_stale[%0d]: got %b expected 0", t, w_out_valid); end
    end
  endtask

`ifdef ADDER_PIPE_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    op = 1'b0;
    in_valid = 1'b1; a = 32'h007F7F7F; b = 32'h00010101;
    tick();
    a = 32'h0000007F; b = 32'h00000001;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (w_ovf_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL stats_initial: got %0d expected 0", w_ovf_count); end
    tick();
    tests_run++;
    if (w_ovf_count !== 16'd3) begin tests_failed++; $display("[TB] FAIL stats_first: got %0d expected 3", w_ovf_count); end
    tick();
    tests_run++;
    if (w_ovf_count !== 16'd4 || s_ovf_count !== 16'd4) begin tests_failed++; $display("[TB] FAIL stats_second: got %0d/%0d expected 4", w_ovf_count, s_ovf_count); end
    rst = 1'b1;
    #1;
    tests_run++;
    if (w_ovf_count !== 16'd0) begin tests_failed++; $display("[TB] FAIL stats_reset: got %0d expected 0", w_ovf_count); end
    tick();
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_add();
    test_overflow_add();
    test_subtract();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef ADDER_PIPE_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
